// File: rtl/demux_stream_3.sv
// demux_stream_3: registered 1-to-3 valid/ready stream demultiplexer.
// Define DEMUX_DROP_CNT_EN to add the saturating drop_cnt output.
module demux_stream_3 #(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       s,
  input  logic             i_valid,
  output logic             i_ready,
`ifdef DEMUX_DROP_CNT_EN
  output logic [7:0]       drop_cnt,
`endif
  output logic [WIDTH-1:0] oa,
  output logic [WIDTH-1:0] ob,
  output logic [WIDTH-1:0] oc,
  output logic             oa_valid,
  output logic             ob_valid,
  output logic             oc_valid,
  input  logic             oa_ready,
  input  logic             ob_ready,
  input  logic             oc_ready
);

  logic             sel_a;
  logic             sel_b;
  logic             sel_c;
  logic             sel_x;
  logic             accept;
  logic [2:0]       rdy;
  logic [2:0]       ld;
  logic [2:0]       vld_q;
  logic [2:0]       vld_d;
  logic [WIDTH-1:0] dat_q [3];
  logic [WIDTH-1:0] dat_d [3];

  always_comb begin
    sel_a = (s == 2'b00);
    sel_b = (s == 2'b01);
    sel_c = (s == 2'b10);
    sel_x = (s == 2'b11);
  end

  // Unmapped select always accepts so the bus never stalls on it.
  always_comb begin
    i_ready = 1'b0;
    unique case (1'b1)
      sel_a: i_ready = !vld_q[0] || oa_ready;
      sel_b: i_ready = !vld_q[1] || ob_ready;
      sel_c: i_ready = !vld_q[2] || oc_ready;
      sel_x: i_ready = 1'b1;
      default: i_ready = 1'b0;
    endcase
    if (CLR) i_ready = 1'b0;
  end

  assign accept = i_valid && i_ready;

  always_comb begin
    rdy = {oc_ready, ob_ready, oa_ready};
    ld  = {3{accept}} & {sel_c, sel_b, sel_a};
    for (int k = 0; k < 3; k++) begin
      vld_d[k] = ld[k] | (vld_q[k] & ~rdy[k]);
      dat_d[k] = ld[k] ? i : dat_q[k];
    end
  end

  always_ff @(posedge C) begin
    if (CLR) begin
      vld_q <= '0;
      for (int k = 0; k < 3; k++) dat_q[k] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < 3; k++) dat_q[k] <= dat_d[k];
    end
  end

  assign oa       = dat_q[0];
  assign ob       = dat_q[1];
  assign oc       = dat_q[2];
  assign oa_valid = vld_q[0];
  assign ob_valid = vld_q[1];
  assign oc_valid = vld_q[2];

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_q;
  logic [7:0] drop_d;

  always_comb begin
    drop_d = drop_q;
    if (accept && sel_x && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge C) begin
    if (CLR) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux_stream_3.sv
// tb_demux_stream_3: vector table plus scoreboard bench for demux_stream_3.
// Build with DEMUX_DROP_CNT_EN defined to also cover drop_cnt.
module tb_demux_stream_3;
  localparam int W = 8;

  logic         C = 1'b0;
  logic         CLR;
  logic [W-1:0] i;
  logic [1:0]   s;
  logic         i_valid;
  logic         i_ready;
  logic [W-1:0] oa, ob, oc;
  logic         oa_valid, ob_valid, oc_valid;
  logic         oa_ready, ob_ready, oc_ready;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0]   drop_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  bit mon_en = 1'b0;

  logic [W-1:0] qa[$], qb[$], qc[$];
  logic [W-1:0] la = '0, lb = '0, lc = '0;

  typedef struct {
    bit         clr;
    bit         iv;
    logic [1:0] sel;
    logic [7:0] d;
    bit         ra, rb, rc;
    bit         exp_rdy;
  } vec_t;

  vec_t tbl[15];

  always #5 C = ~C;

  demux_stream_3 #(.WIDTH(W)) dut (
    .C(C),
    .CLR(CLR),
    .i(i),
    .s(s),
    .i_valid(i_valid),
    .i_ready(i_ready),
`ifdef DEMUX_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .oa(oa),
    .ob(ob),
    .oc(oc),
    .oa_valid(oa_valid),
    .ob_valid(ob_valid),
    .oc_valid(oc_valid),
    .oa_ready(oa_ready),
    .ob_ready(ob_ready),
    .oc_ready(oc_ready)
  );

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Scoreboard: compare state before each edge, then apply the edge.
  always @(negedge C) begin
    if (mon_en) begin
      bit er;
      er = CLR ? 1'b0 :
           (s == 2'b11) ? 1'b1 :
           (s == 2'b00) ? (qa.size() == 0 || oa_ready) :
           (s == 2'b01) ? (qb.size() == 0 || ob_ready) :
                          (qc.size() == 0 || oc_ready);
      chk("mon_i_ready", i_ready, er);
      chk("oa_valid", oa_valid, qa.size() != 0);
      chk("ob_valid", ob_valid, qb.size() != 0);
      chk("oc_valid", oc_valid, qc.size() != 0);
      chk("oa", oa, la);
      chk("ob", ob, lb);
      chk("oc", oc, lc);
`ifdef DEMUX_DROP_CNT_EN
      chk("drop_cnt", drop_cnt, exp_drop);
`endif
      if (CLR) begin
        qa.delete(); qb.delete(); qc.delete();
        la = '0; lb = '0; lc = '0;
        exp_drop = 0;
      end else begin
        if (qa.size() != 0 && oa_ready) void'(qa.pop_front());
        if (qb.size() != 0 && ob_ready) void'(qb.pop_front());
        if (qc.size() != 0 && oc_ready) void'(qc.pop_front());
        if (i_valid && er) begin
          case (s)
            2'b00: begin qa.push_back(i); la = i; end
            2'b01: begin qb.push_back(i); lb = i; end
            2'b10: begin qc.push_back(i); lc = i; end
            default: if (exp_drop < 255) exp_drop++;
          endcase
        end
      end
    end
  end

  task automatic drive(input bit clr, input bit iv, input logic [1:0] sel,
                       input logic [7:0] d, input bit ra, input bit rb,
                       input bit rc);
    CLR = clr; i_valid = iv; s = sel; i = d;
    oa_ready = ra; ob_ready = rb; oc_ready = rc;
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    //           clr iv sel    d      ra rb rc rdy
    tbl[0]  = '{1, 0, 2'b00, 8'h00, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 2'b00, 8'hA5, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 2'b00, 8'hA5, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 2'b00, 8'h00, 1, 0, 0, 1};
    tbl[4]  = '{0, 1, 2'b00, 8'h11, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 2'b00, 8'h22, 0, 0, 0, 0};
    tbl[6]  = '{0, 1, 2'b00, 8'h22, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 2'b00, 8'h22, 0, 0, 0, 0};
    tbl[8]  = '{0, 1, 2'b00, 8'h22, 1, 0, 0, 1};
    tbl[9]  = '{0, 0, 2'b01, 8'h00, 1, 0, 0, 1};
    tbl[10] = '{0, 1, 2'b11, 8'h5A, 0, 0, 0, 1};
    tbl[11] = '{0, 1, 2'b10, 8'h33, 0, 0, 0, 1};
    tbl[12] = '{0, 1, 2'b10, 8'h44, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 2'b01, 8'h44, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 2'b00, 8'h00, 1, 1, 1, 1};

    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].clr, tbl[k].iv, tbl[k].sel, tbl[k].d,
            tbl[k].ra, tbl[k].rb, tbl[k].rc);
      @(negedge C);
      chk($sformatf("vec%0d_i_ready", k), i_ready, tbl[k].exp_rdy);
      tick();
      if (k == 0) mon_en = 1'b1;
    end

    // Streaming round-robin with all consumers ready.
    for (int k = 1; k <= 9; k++) begin
      logic [1:0] sel;
      sel = 2'((k - 1) % 3);
      drive(0, 1, sel, 8'(k), 1, 1, 1);
      @(negedge C);
      chk($sformatf("stream%0d_i_ready", k), i_ready, 1'b1);
      tick();
    end
    drive(0, 0, 2'b00, 8'h00, 1, 1, 1);
    tick();

    // Unmapped select flood.
    for (int k = 0; k < 300; k++) begin
      drive(0, 1, 2'b11, 8'($urandom), k[0], k[1], 1'b0);
      @(negedge C);
      chk("drop_i_ready", i_ready, 1'b1);
      tick();
    end
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_sat", drop_cnt, 8'd255);
`endif

    // Reset mid-stream with A and C full.
    drive(0, 1, 2'b00, 8'h77, 0, 0, 0);
    tick();
    drive(0, 1, 2'b10, 8'h88, 0, 0, 0);
    tick();
    chk("pre_rst_oa_valid", oa_valid, 1'b1);
    chk("pre_rst_oc", oc, 8'h88);
    drive(1, 1, 2'b01, 8'h99, 1, 1, 1);
    tick();
    chk("rst_oa", oa, 8'h00);
    chk("rst_ob", ob, 8'h00);
    chk("rst_oc", oc, 8'h00);
    chk("rst_valids", {oa_valid, ob_valid, oc_valid}, 3'b000);
`ifdef DEMUX_DROP_CNT_EN
    chk("rst_drop", drop_cnt, 8'd0);
`endif
    drive(0, 0, 2'b01, 8'h00, 0, 0, 0);
    tick();
    tick();
    chk("post_rst_ob_valid", ob_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
